// File: rtl/player_pkg.sv
// rtl/player_pkg.sv - shared types and constants for the player motion controller
package player_pkg;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2,
    LAND   = 2'd3
  } mstate_t;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_A = 8'h04;

  localparam int DEF_WALK_SPEED  = 1;
  localparam int DEF_JUMP_SPEED  = 3;
  localparam int DEF_FALL_SPEED  = 3;
  localparam int DEF_JUMP_FRAMES = 40;
  localparam int DEF_CEIL_Y      = 250;
  localparam int DEF_X_MIN       = 10;
  localparam int DEF_SCROLL_X    = 320;
  localparam int DEF_SCROLL_MAX  = 60;

  // A key counts as held when either keyboard slot reports it.
  function automatic logic key_hit(input logic [7:0] slot0, input logic [7:0] slot1,
                                   input logic [7:0] key);
    return (slot0 == key) || (slot1 == key);
  endfunction

endpackage

// File: rtl/player_motion_ctrl_key_decode.sv
// rtl/player_motion_ctrl_key_decode.sv - two-slot keycode match with W press edge detect
module key_decode
  import player_pkg::*;
(
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic [7:0] keycode1,
  output logic       w,
  output logic       a,
  output logic       d,
  output logic       w_edge
);

  logic w_prev;

  assign w = key_hit(keycode, keycode1, KEY_W);
  assign a = key_hit(keycode, keycode1, KEY_A);
  assign d = key_hit(keycode, keycode1, KEY_D);

  assign w_edge = w & ~w_prev;

  // Starts high so a W held while reset releases is not seen as a fresh press.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      w_prev <= 1'b1;
    end else begin
      w_prev <= w;
    end
  end

endmodule

// File: rtl/player_motion_ctrl.sv
// rtl/player_motion_ctrl.sv - per-frame walk, jump/fall and scroll sequencer for the player sprite
module player_motion_ctrl
  import player_pkg::*;
#(
  parameter int WALK_SPEED  = DEF_WALK_SPEED,
  parameter int JUMP_SPEED  = DEF_JUMP_SPEED,
  parameter int FALL_SPEED  = DEF_FALL_SPEED,
  parameter int JUMP_FRAMES = DEF_JUMP_FRAMES,
  parameter int CEIL_Y      = DEF_CEIL_Y,
  parameter int X_MIN       = DEF_X_MIN,
  parameter int SCROLL_X    = DEF_SCROLL_X,
  parameter int SCROLL_MAX  = DEF_SCROLL_MAX
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic [7:0] keycode1,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  input  logic [9:0] floor_y,
  input  logic       wall_right,
  output logic [9:0] x_step,
  output logic [9:0] y_step,
  output logic       scroll_inc,
  output logic [5:0] scroll_offset,
  output logic [1:0] mstate,
  output logic       anim_tick
);

  localparam int RCW = $clog2(JUMP_FRAMES + 1);

  localparam logic [9:0]     WALK_POS   = 10'(WALK_SPEED);
  localparam logic [9:0]     WALK_NEG   = 10'(-WALK_SPEED);
  localparam logic [9:0]     RISE_STEP  = 10'(-JUMP_SPEED);
  localparam logic [9:0]     FALL_MAX   = 10'(FALL_SPEED);
  localparam logic [9:0]     CEIL_LIM   = 10'(CEIL_Y);
  localparam logic [9:0]     LEFT_LIM   = 10'(X_MIN + WALK_SPEED);
  localparam logic [9:0]     SCROLL_LIM = 10'(SCROLL_X);
  localparam logic [5:0]     SCROLL_TOP = 6'(SCROLL_MAX);
  localparam logic [RCW-1:0] RISE_LOAD  = RCW'(JUMP_FRAMES - 1);

  logic w, a, d, w_edge;

  mstate_t        state, next_state;
  logic [RCW-1:0] rise_cnt, rise_cnt_next;
  logic [2:0]     anim_cnt, anim_cnt_next;
  logic [9:0]     gap;
  logic           rise_done;

  logic [9:0] x_step_next, y_step_next;
  logic       scroll_next, anim_tick_next, moving;
  logic       go_right, go_left;

  key_decode u_key_decode (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .keycode1  (keycode1),
    .w         (w),
    .a         (a),
    .d         (d),
    .w_edge    (w_edge)
  );

  // Distance left to the floor; a player already below it is treated as landed.
  assign gap       = (player_y > floor_y) ? 10'd0 : (floor_y - player_y);
  assign rise_done = (rise_cnt == '0) || (player_y <= CEIL_LIM);
  assign go_right  = d & ~a;
  assign go_left   = a & ~d;
  assign mstate    = state;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state <= GROUND;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state    = state;
    rise_cnt_next = rise_cnt;
    case (state)
      GROUND: begin
        if (w_edge) begin
          next_state    = RISE;
          rise_cnt_next = RISE_LOAD;
        end else if (player_y < floor_y) begin
          next_state = FALL;
        end
      end
      RISE: begin
        if (rise_done) begin
          next_state = FALL;
        end else begin
          rise_cnt_next = rise_cnt - RCW'(1);
        end
      end
      FALL: begin
        if (gap <= FALL_MAX) begin
          next_state = LAND;
        end
      end
      LAND:    next_state = GROUND;
      default: next_state = GROUND;
    endcase
  end

  always_comb begin
    y_step_next = '0;
    case (state)
      GROUND:  y_step_next = w_edge ? RISE_STEP : 10'd0;
      RISE:    y_step_next = rise_done ? 10'd0 : RISE_STEP;
      FALL:    y_step_next = (gap > FALL_MAX) ? FALL_MAX : gap;
      default: y_step_next = '0;
    endcase

    // Rightward walking past the scroll column moves the background until it saturates.
    x_step_next = '0;
    scroll_next = 1'b0;
    if (go_right) begin
      if (!wall_right) begin
        if ((player_x >= SCROLL_LIM) && (scroll_offset < SCROLL_TOP)) begin
          scroll_next = 1'b1;
        end else begin
          x_step_next = WALK_POS;
        end
      end
    end else if (go_left) begin
      if (player_x > LEFT_LIM) begin
        x_step_next = WALK_NEG;
      end
    end

    moving         = (x_step_next != '0) || scroll_next;
    anim_cnt_next  = moving ? (anim_cnt + 3'd1) : anim_cnt;
    anim_tick_next = moving && (anim_cnt == 3'd7);
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      x_step        <= '0;
      y_step        <= '0;
      scroll_inc    <= 1'b0;
      scroll_offset <= '0;
      anim_tick     <= 1'b0;
      anim_cnt      <= '0;
      rise_cnt      <= '0;
    end else begin
      x_step        <= x_step_next;
      y_step        <= y_step_next;
      scroll_inc    <= scroll_next;
      scroll_offset <= scroll_offset + 6'(scroll_next);
      anim_tick     <= anim_tick_next;
      anim_cnt      <= anim_cnt_next;
      rise_cnt      <= rise_cnt_next;
    end
  end

endmodule

// File: tb/tb_player_motion_ctrl.sv
// tb/tb_player_motion_ctrl.sv - directed bench for player_motion_ctrl with a behavioural motion model
module tb_player_motion_ctrl;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode, keycode1;
  logic [9:0] player_x, player_y, floor_y;
  logic       wall_right;
  logic [9:0] x_step, y_step;
  logic       scroll_inc;
  logic [5:0] scroll_offset;
  logic [1:0] mstate;
  logic       anim_tick;

  player_motion_ctrl dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .keycode       (keycode),
    .keycode1      (keycode1),
    .player_x      (player_x),
    .player_y      (player_y),
    .floor_y       (floor_y),
    .wall_right    (wall_right),
    .x_step        (x_step),
    .y_step        (y_step),
    .scroll_inc    (scroll_inc),
    .scroll_offset (scroll_offset),
    .mstate        (mstate),
    .anim_tick     (anim_tick)
  );

  always #5 frame_clk = ~frame_clk;

  int total = 0;
  int bad   = 0;

  // Sprite datapath stand-in
  int px, py, fy;

  // Motion model: phase 0 ground, 1 rising, 2 falling, 3 landing
  int m_state, m_rise, m_off, m_moves;
  bit m_wprev;
  int e_x, e_y, e_scr, e_tick, e_state;

  int frame_no, n_scr, n_tick, tick_sum, min_y;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    player_x = 10'(px);
    player_y = 10'(py);
    floor_y  = 10'(fy);
  endtask

  task automatic model_reset();
    m_state = 0; m_rise = 0; m_off = 0; m_moves = 0; m_wprev = 1'b1;
    e_x = 0; e_y = 0; e_scr = 0; e_tick = 0; e_state = 0;
  endtask

  task automatic model_step();
    bit w, a, d, w_rise, right, left;
    int gap;
    w = (keycode == 8'h1A) || (keycode1 == 8'h1A);
    a = (keycode == 8'h04) || (keycode1 == 8'h04);
    d = (keycode == 8'h07) || (keycode1 == 8'h07);
    w_rise  = w && !m_wprev;
    m_wprev = w;

    e_y = 0;
    case (m_state)
      0: if (w_rise) begin m_state = 1; m_rise = 39; e_y = -3; end
         else if (py < fy) m_state = 2;
      1: if (m_rise == 0 || py <= 250) m_state = 2;
         else begin e_y = -3; m_rise--; end
      2: begin
        gap = (py > fy) ? 0 : fy - py;
        if (gap > 3) e_y = 3;
        else begin e_y = gap; m_state = 3; end
      end
      default: m_state = 0;
    endcase
    e_state = m_state;

    right = d && !a;
    left  = a && !d;
    e_x = 0; e_scr = 0;
    if (right) begin
      if (!wall_right) begin
        if (px >= 320 && m_off < 60) begin e_scr = 1; m_off++; end
        else e_x = 1;
      end
    end else if (left) begin
      if (px > 11) e_x = -1;
    end

    e_tick = 0;
    if (e_x != 0 || e_scr != 0) begin
      m_moves++;
      e_tick = (m_moves % 8 == 0) ? 1 : 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge frame_clk);
    #1;
    frame_no++;
    chk("x_step",        int'($signed(x_step)), e_x);
    chk("y_step",        int'($signed(y_step)), e_y);
    chk("scroll_inc",    int'(scroll_inc),      e_scr);
    chk("scroll_offset", int'(scroll_offset),   m_off);
    chk("mstate",        int'(mstate),          e_state);
    chk("anim_tick",     int'(anim_tick),       e_tick);
    if (scroll_inc) n_scr++;
    if (anim_tick) begin n_tick++; tick_sum += frame_no; end
    px += e_x;
    py += e_y;
    if (py < min_y) min_y = py;
    drive();
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_x"},    int'(x_step),        0);
    chk({name, "_y"},    int'(y_step),        0);
    chk({name, "_scr"},  int'(scroll_inc),    0);
    chk({name, "_off"},  int'(scroll_offset), 0);
    chk({name, "_st"},   int'(mstate),        0);
    chk({name, "_anim"}, int'(anim_tick),     0);
  endtask

  task automatic run_to_ground(input string name);
    for (int i = 0; i < 200 && m_state != 0; i++) tick();
    chk(name, int'(mstate), 0);
  endtask

  initial begin
    int n3, rise_frames;
    bit seen_land;

    // 1: W held through reset release must not jump
    Reset = 1'b1; keycode = 8'h1A; keycode1 = 8'h00; wall_right = 1'b0;
    px = 100; py = 378; fy = 378; drive();
    model_reset();
    frame_no = 0; n_scr = 0; n_tick = 0; tick_sum = 0; min_y = 1000;
    repeat (2) begin @(posedge frame_clk); #1; chk_zero("reset"); end
    Reset = 1'b0;
    repeat (5) tick();
    chk("t1_no_jump_state", int'(mstate), 0);
    chk("t1_no_jump_step", int'(y_step), 0);
    keycode = 8'h00; tick();
    keycode = 8'h1A; tick();
    chk("t1_rise_state", int'(mstate), 1);
    chk("t1_rise_step", int'(y_step), 10'h3FD);

    // 2: full jump, W taps during fall and landing ignored
    seen_land = 1'b0;
    for (int i = 0; i < 200 && !(seen_land && m_state == 0); i++) begin
      keycode = ((m_state == 2 && i % 2 == 0) || m_state == 3) ? 8'h1A : 8'h00;
      tick();
      if (m_state == 3) begin
        seen_land = 1'b1;
        chk("t2_last_fall_step", int'(y_step), 3);
      end
    end
    chk("t2_landed", int'(mstate), 0);
    chk("t2_peak_y", min_y, 258);
    chk("t2_land_y", py, 378);
    tick();
    chk("t2_held_w_no_jump", int'(mstate), 0);
    keycode = 8'h00; tick();

    // 3: ceiling abort
    py = 270; fy = 270; drive();
    tick();
    keycode = 8'h1A; tick();
    keycode = 8'h00;
    rise_frames = 1;
    for (int i = 0; i < 60 && m_state != 2; i++) begin
      tick();
      if (int'($signed(y_step)) == -3) rise_frames++;
    end
    chk("t3_fall_state", int'(mstate), 2);
    chk("t3_rise_frames", rise_frames, 7);
    chk("t3_ceiling_y", py, 249);
    run_to_ground("t3_back_on_ground");

    // 4: walk off a ledge
    py = 332; fy = 332; drive();
    tick(); tick();
    fy = 378; drive();
    tick();
    chk("t4_fall_state", int'(mstate), 2);
    n3 = 0;
    for (int i = 0; i < 60 && m_state != 3; i++) begin
      tick();
      if (m_state != 3 && int'(y_step) == 3) n3++;
    end
    chk("t4_full_steps", n3, 15);
    chk("t4_last_step", int'(y_step), 1);
    chk("t4_land_y", py, 378);
    tick();

    // Asynchronous reset in the middle of a jump
    tick();
    keycode = 8'h1A; tick();
    keycode = 8'h00; tick(); tick();
    chk("rst_pre_rise", int'(mstate), 1);
    #2 Reset = 1'b1;
    #1 chk_zero("async_reset");
    model_reset();
    @(posedge frame_clk); #1;
    chk_zero("async_reset_hold");
    py = 378; fy = 378; drive();
    Reset = 1'b0;

    // 5: scroll saturation and animation cadence
    px = 320; drive();
    keycode = 8'h07;
    frame_no = 0; n_scr = 0; n_tick = 0; tick_sum = 0;
    repeat (70) tick();
    chk("t5_scroll_pulses", n_scr, 60);
    chk("t5_scroll_offset", int'(scroll_offset), 60);
    chk("t5_final_x", px, 330);
    chk("t5_last_x_step", int'(x_step), 1);
    chk("t5_anim_ticks", n_tick, 8);
    chk("t5_anim_frame_sum", tick_sum, 288);

    // 6: wall, left limit, conflicting keys
    n_tick = 0;
    wall_right = 1'b1;
    repeat (3) tick();
    chk("t6_wall_x", int'(x_step), 0);
    chk("t6_wall_anim", n_tick, 0);
    wall_right = 1'b0;
    keycode = 8'h04; px = 11; drive();
    tick();
    chk("t6_left_limit", int'(x_step), 0);
    px = 12; drive();
    tick();
    chk("t6_left_step", int'(x_step), 10'h3FF);
    keycode = 8'h04; keycode1 = 8'h07; px = 200; drive();
    tick();
    chk("t6_both_keys", int'(x_step), 0);
    keycode = 8'h00;
    tick();
    chk("t6_slot1_right", int'(x_step), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/player_motion_ctrl.md
Name: player_motion_ctrl

Overview:
- Per-frame motion sequencer for the player sprite. Decodes both keyboard keycode slots into walk and jump intent, then runs the jump/fall state machine.
- Issues signed x/y step commands and screen-scroll increments to the sprite position datapath. The datapath integrates these each frame and feeds back its current position.
- The platform lookup supplies the floor height under the player; the controller owns all gravity, landing and scroll-limit decisions.

Parameters:
- WALK_SPEED, 1, |x_step| per frame while walking
- JUMP_SPEED, 3, |y_step| per frame while rising
- FALL_SPEED, 3, maximum y_step per frame while falling
- JUMP_FRAMES, 40, maximum frames in RISE
- CEIL_Y, 250, rising aborts when player_y <= CEIL_Y
- X_MIN, 10, left walk limit
- SCROLL_X, 320, screen x at or beyond which rightward walking scrolls instead of moving
- SCROLL_MAX, 60, maximum scroll_offset

Ports:
- frame_clk  in  1  frame-rate clock (one edge per video frame)
- Reset  in  1  asynchronous reset, active-high
- keycode  in  8  keyboard slot 0
- keycode1  in  8  keyboard slot 1
- player_x  in  10  current sprite screen x (unsigned)
- player_y  in  10  current sprite y, top-down (unsigned)
- floor_y  in  10  y of the supporting surface below the player
- wall_right  in  1  solid block immediately right of the player
- x_step  out  10  signed two's-complement x delta for the next frame
- y_step  out  10  signed y delta for the next frame
- scroll_inc  out  1  one-frame pulse: advance background by 1
- scroll_offset  out  6  accumulated scroll count
- mstate  out  2  GROUND=0, RISE=1, FALL=2, LAND=3
- anim_tick  out  1  walk-animation advance pulse

Behaviour:
- Reset state: all outputs 0, mstate=GROUND, rise_cnt=0, anim_cnt=0.
  - w_prev resets to 1. A W key held through reset release does not jump.
- Key decode: an intent is active if either slot matches.
  - W=0x1A, D=0x07, A=0x04.
  - w_edge = W & ~w_prev. w_prev <= W every frame.
- All outputs are registered. Each value is computed from the current inputs and state, and takes effect at the next frame_clk edge (1-frame latency).
- Vertical FSM:
  - GROUND
    - If w_edge: go to RISE, load rise_cnt=JUMP_FRAMES-1, y_step=-JUMP_SPEED.
    - Else if player_y < floor_y (walked off a ledge): go to FALL.
    - Otherwise y_step=0.
  - RISE
    - If rise_cnt==0 or player_y <= CEIL_Y: go to FALL, y_step=0.
    - Otherwise y_step=-JUMP_SPEED and rise_cnt decrements.
    - W edges are ignored.
  - FALL
    - Compute gap = floor_y - player_y (unsigned; treat player_y > floor_y as gap=0).
    - If gap > FALL_SPEED: y_step=+FALL_SPEED, stay in FALL.
    - Otherwise y_step=gap (exact landing) and go to LAND.
    - No double jump: W edges are ignored.
  - LAND: y_step=0 for exactly one frame, then go to GROUND. A w_edge during LAND is ignored.
- Horizontal (evaluated in every state):
  - D&~A → right. A&~D → left. Both or neither → x_step=0.
  - Right:
    - If wall_right: x_step=0, no scroll.
    - Else if player_x >= SCROLL_X and scroll_offset < SCROLL_MAX: x_step=0, scroll_inc=1, scroll_offset+1.
    - Else x_step=+WALK_SPEED.
  - When scroll_offset==SCROLL_MAX, scrolling saturates and the player walks normally.
  - Left: if player_x <= X_MIN+WALK_SPEED then x_step=0, else x_step=-WALK_SPEED. Left never decrements scroll_offset.
- anim_tick:
  - The 3-bit anim_cnt increments on frames where x_step≠0 or scroll_inc=1.
  - anim_tick=1 on the frame anim_cnt wraps from 7 to 0.
  - When idle, anim_cnt holds its value.
- Arithmetic:
  - Steps are 10-bit two's complement; negative steps sign-extend to 10 bits.
  - gap is computed at 10 bits. No value wraps.
- Reset asserted mid-jump returns every register to its reset value on the same cycle.

Decomposition:
- Package player_pkg:
  - mstate enum (GROUND/RISE/FALL/LAND)
  - key constants KEY_W=8'h1A, KEY_D=8'h07, KEY_A=8'h04
  - default speed and limit constants
- Sub-module key_decode:
  - Combinational two-slot match to w/a/d.
  - Includes the registered w_prev edge detector.
- The FSM, horizontal logic and counters stay in player_motion_ctrl.

Test Plan:
- Bench setup: the bench integrates player_x += x_step and player_y += y_step each frame.
1. Reset with W held, floor_y=378, player_y=378 → mstate stays GROUND, y_step=0 for 5 frames; release W, press again → RISE on the next edge, y_step=-3 (10'h3FD).
2. Jump from y=378, floor 378 → 40 RISE frames reach y=258, then FALL steps +3 ×39 to y=375, final gap=3 → y_step=3, LAND, then GROUND at y=378; W presses during the fall produce no RISE.
3. Ceiling: jump from player_y=270 → RISE ends when y<=250 (after 7 frames, y=249), then FALL.
4. Ledge: GROUND at y=332, floor_y switches to 378 → FALL next frame; lands exactly at 378 with a final y_step of 1 (46 = 15×3 + 1).
5. Scroll: hold D with player_x=320 for 70 frames → 60 scroll_inc pulses with x_step=0, then x_step=+1 ×10, scroll_offset=60; anim_tick pulses at frames 8, 16, … 64.
6. Walls and limits: D with wall_right=1 → x_step=0, no anim_tick; A at player_x=11 → x_step=0; A+D together → x_step=0.
